// File: rtl/drive_arbiter.sv
// drive_arbiter
// Chooses the robot's drive command from the obstacle sensor, the IR remote
// and the camera classifier, and hands it to the UART JSON transmitter
// over a valid/ready handshake.
//
// Ports:
//   clk_50, reset      - 50 MHz clock, asynchronous active-high reset
//   ir_cmd, ir_valid   - IR button code and its one-cycle strobe
//   cam_dir            - camera direction (0 none, 1 left, 2 centre, 3 right, 4-7 none)
//   orange_detected    - target currently visible
//   distance, dist_valid - ultrasonic range and its one-cycle strobe
//   drive_state, mode  - arbitrated command and current mode
//   blocked            - obstacle latch
//   cmd_valid, cmd_state, cmd_ready - transmit handshake toward the UART side
module drive_arbiter #(
    parameter int unsigned STABLE_CYCLES  = 250000,
    parameter int unsigned MANUAL_TIMEOUT = 100000000,
    parameter int unsigned HEARTBEAT      = 25000000,
    parameter int unsigned DIST_W         = 18,
    parameter int unsigned STOP_DIST      = 20,
    parameter int unsigned CLEAR_DIST     = 30
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic [7:0]        ir_cmd,
    input  logic              ir_valid,
    input  logic [2:0]        cam_dir,
    input  logic              orange_detected,
    input  logic [DIST_W-1:0] distance,
    input  logic              dist_valid,
    output logic [3:0]        drive_state,
    output logic [1:0]        mode,
    output logic              cmd_valid,
    output logic [3:0]        cmd_state,
    input  logic              cmd_ready,
    output logic              blocked
);

    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TMO_W  = $clog2(MANUAL_TIMEOUT + 1);
    localparam int unsigned HB_W   = $clog2(HEARTBEAT + 1);

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(MANUAL_TIMEOUT - 1);
    localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HEARTBEAT - 1);
    localparam logic [DIST_W-1:0] STOP_THR  = DIST_W'(STOP_DIST);
    localparam logic [DIST_W-1:0] CLEAR_THR = DIST_W'(CLEAR_DIST);

    localparam logic [1:0] MODE_IDLE    = 2'd0;
    localparam logic [1:0] MODE_AUTO    = 2'd1;
    localparam logic [1:0] MODE_MANUAL  = 2'd2;
    localparam logic [1:0] MODE_BLOCKED = 2'd3;

    localparam logic [3:0] DRV_STOP   = 4'd0;
    localparam logic [3:0] DRV_FWD    = 4'd1;
    localparam logic [3:0] DRV_LEFT   = 4'd2;
    localparam logic [3:0] DRV_RIGHT  = 4'd3;
    localparam logic [3:0] DRV_REV    = 4'd4;
    localparam logic [3:0] DRV_SEARCH = 4'd5;

    localparam logic [0:0] IDLE_TX  = 1'b0;
    localparam logic [0:0] WAIT_ACK = 1'b1;

    // ---------------- obstacle latch with hysteresis ----------------
    logic blocked_reg;

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            blocked_reg <= 1'b0;
        end else if (dist_valid) begin
            // a zero reading means no echo came back: treat it as an obstacle
            if (distance == '0 || distance < STOP_THR)
                blocked_reg <= 1'b1;
            else if (distance >= CLEAR_THR)
                blocked_reg <= 1'b0;
        end
    end

    // ---------------- camera direction filter ----------------
    logic [1:0]        cam_norm;
    logic [1:0]        cand_reg;
    logic [1:0]        cam_filt_reg;
    logic [STAB_W-1:0] stab_cnt_reg;
    logic [STAB_W-1:0] stab_cnt_next;

    assign cam_norm = cam_dir[2] ? 2'd0 : cam_dir[1:0];

    always_comb begin
        stab_cnt_next = '0;
        if (cam_norm == cand_reg) begin
            if (stab_cnt_reg == STAB_LAST)
                stab_cnt_next = stab_cnt_reg;
            else
                stab_cnt_next = stab_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            cand_reg     <= 2'd0;
            stab_cnt_reg <= '0;
            cam_filt_reg <= 2'd0;
        end else begin
            cand_reg     <= cam_norm;
            stab_cnt_reg <= stab_cnt_next;
            // reloads the same value every cycle once saturated; harmless
            if (stab_cnt_next == STAB_LAST)
                cam_filt_reg <= cam_norm;
        end
    end

    // ---------------- IR decode, mode and drive selection ----------------
    logic [1:0]       mode_reg, mode_next, saved_mode_reg, base_mode, want_mode;
    logic [3:0]       manual_cmd_reg, manual_cmd_next;
    logic [3:0]       drive_state_reg, drive_next;
    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic             ir_manual, ir_auto, ir_idle, timeout_hit;
    logic [3:0]       ir_drive;

    always_comb begin
        ir_manual = 1'b0;
        ir_auto   = 1'b0;
        ir_idle   = 1'b0;
        ir_drive  = DRV_STOP;
        if (ir_valid) begin
            case (ir_cmd)
                8'h01:   begin ir_manual = 1'b1; ir_drive = DRV_FWD;   end
                8'h02:   begin ir_manual = 1'b1; ir_drive = DRV_REV;   end
                8'h03:   begin ir_manual = 1'b1; ir_drive = DRV_LEFT;  end
                8'h04:   begin ir_manual = 1'b1; ir_drive = DRV_RIGHT; end
                8'h05:   begin ir_manual = 1'b1; ir_drive = DRV_STOP;  end
                8'h0A:   ir_auto = 1'b1;
                8'h0B:   ir_idle = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        // while blocked, IR commands and the timeout act on the saved mode
        base_mode       = (mode_reg == MODE_BLOCKED) ? saved_mode_reg : mode_reg;
        timeout_hit     = (mode_reg == MODE_MANUAL) && (tmo_cnt_reg == TMO_LAST);
        want_mode       = base_mode;
        manual_cmd_next = manual_cmd_reg;
        if (ir_manual) begin
            want_mode       = MODE_MANUAL;
            manual_cmd_next = ir_drive;
        end else if (ir_auto) begin
            want_mode = MODE_AUTO;
        end else if (ir_idle) begin
            want_mode = MODE_IDLE;
        end else if (timeout_hit) begin
            want_mode = MODE_AUTO;
        end
        mode_next = blocked_reg ? MODE_BLOCKED : want_mode;

        // the manual timeout is frozen while blocked so the restored
        // manual session resumes where it left off
        if (ir_manual)
            tmo_cnt_next = '0;
        else if (mode_reg == MODE_MANUAL && !timeout_hit)
            tmo_cnt_next = tmo_cnt_reg + 1'b1;
        else if (mode_reg == MODE_BLOCKED)
            tmo_cnt_next = tmo_cnt_reg;
        else
            tmo_cnt_next = '0;

        drive_next = DRV_STOP;
        case (mode_next)
            MODE_MANUAL: drive_next = manual_cmd_next;
            MODE_AUTO: begin
                if (!orange_detected || cam_filt_reg == 2'd0)
                    drive_next = DRV_SEARCH;
                else if (cam_filt_reg == 2'd1)
                    drive_next = DRV_LEFT;
                else if (cam_filt_reg == 2'd2)
                    drive_next = DRV_FWD;
                else
                    drive_next = DRV_RIGHT;
            end
            default: drive_next = DRV_STOP;
        endcase
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            mode_reg        <= MODE_IDLE;
            saved_mode_reg  <= MODE_IDLE;
            manual_cmd_reg  <= DRV_STOP;
            tmo_cnt_reg     <= '0;
            drive_state_reg <= DRV_STOP;
        end else begin
            mode_reg        <= mode_next;
            manual_cmd_reg  <= manual_cmd_next;
            tmo_cnt_reg     <= tmo_cnt_next;
            drive_state_reg <= drive_next;
            if (blocked_reg)
                saved_mode_reg <= want_mode;
        end
    end

    // ---------------- transmit sequencing ----------------
    logic [0:0]      tx_state_reg;
    logic [3:0]      cmd_state_reg;
    logic [3:0]      last_sent_reg;
    logic [HB_W-1:0] hb_cnt_reg;

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            tx_state_reg  <= IDLE_TX;
            cmd_state_reg <= DRV_STOP;
            last_sent_reg <= DRV_STOP;
            hb_cnt_reg    <= '0;
        end else begin
            case (tx_state_reg)
                IDLE_TX: begin
                    if (drive_state_reg != last_sent_reg || hb_cnt_reg == HB_LAST) begin
                        tx_state_reg  <= WAIT_ACK;
                        cmd_state_reg <= drive_state_reg;
                    end else begin
                        hb_cnt_reg <= hb_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    // cmd_state is frozen here; a newer drive_state is
                    // picked up as a mismatch once back in IDLE_TX
                    if (cmd_ready) begin
                        tx_state_reg  <= IDLE_TX;
                        last_sent_reg <= cmd_state_reg;
                        hb_cnt_reg    <= '0;
                    end
                end
            endcase
        end
    end

    assign drive_state = drive_state_reg;
    assign mode        = mode_reg;
    assign blocked     = blocked_reg;
    assign cmd_valid   = (tx_state_reg == WAIT_ACK);
    assign cmd_state   = cmd_state_reg;

endmodule

// File: tb/tb_drive_arbiter.sv
// Testbench for drive_arbiter: directed scenarios followed by a randomized
// run compared every cycle against a behavioural model of the arbiter.
module tb_drive_arbiter;

    localparam int S      = 4;
    localparam int T      = 20;
    localparam int H      = 50;
    localparam int DW     = 18;
    localparam int STOPD  = 20;
    localparam int CLEARD = 30;

    logic          clk_50 = 1'b0;
    logic          reset  = 1'b1;
    logic [7:0]    ir_cmd = 8'd0;
    logic          ir_valid = 1'b0;
    logic [2:0]    cam_dir = 3'd0;
    logic          orange_detected = 1'b0;
    logic [DW-1:0] distance = '0;
    logic          dist_valid = 1'b0;
    logic [3:0]    drive_state;
    logic [1:0]    mode;
    logic          cmd_valid;
    logic [3:0]    cmd_state;
    logic          cmd_ready = 1'b1;
    logic          blocked;

    int total = 0;
    int bad   = 0;

    always #5 clk_50 = ~clk_50;

    drive_arbiter #(
        .STABLE_CYCLES (S),
        .MANUAL_TIMEOUT(T),
        .HEARTBEAT     (H),
        .DIST_W        (DW),
        .STOP_DIST     (STOPD),
        .CLEAR_DIST    (CLEARD)
    ) dut (
        .clk_50         (clk_50),
        .reset          (reset),
        .ir_cmd         (ir_cmd),
        .ir_valid       (ir_valid),
        .cam_dir        (cam_dir),
        .orange_detected(orange_detected),
        .distance       (distance),
        .dist_valid     (dist_valid),
        .drive_state    (drive_state),
        .mode           (mode),
        .cmd_valid      (cmd_valid),
        .cmd_state      (cmd_state),
        .cmd_ready      (cmd_ready),
        .blocked        (blocked)
    );

    // ---------------- behavioural reference model ----------------
    // m_want is the mode the operator asked for; an obstacle only masks it.
    // m_run is how many consecutive edges the same direction has been seen.
    int m_dir = 0, m_run = 1, m_filt = 0;
    int m_blk = 0, m_want = 0, m_mode = 0, m_man = 0, m_age = 0, m_drive = 0;
    int m_pend = 0, m_cmd = 0, m_last = 0, m_idle = 0;

    task automatic model_reset();
        m_dir = 0; m_run = 1; m_filt = 0;
        m_blk = 0; m_want = 0; m_mode = 0; m_man = 0; m_age = 0; m_drive = 0;
        m_pend = 0; m_cmd = 0; m_last = 0; m_idle = 0;
    endtask

    task automatic model_step();
        int dir, run_n, filt_n, blk_n, want_n, man_n, age_n, mode_n, drive_n;
        int pend_n, cmd_n, last_n, idle_n;
        bit rec;
        dir    = (cam_dir > 3) ? 0 : int'(cam_dir);
        run_n  = (dir == m_dir) ? m_run + 1 : 1;
        if (run_n > 100000) run_n = 100000;
        filt_n = (run_n >= S) ? dir : m_filt;

        blk_n = m_blk;
        if (dist_valid) begin
            if (int'(distance) < STOPD) blk_n = 1;
            else if (int'(distance) >= CLEARD) blk_n = 0;
        end

        want_n = m_want; man_n = m_man; age_n = m_age; rec = 0;
        if (ir_valid) begin
            case (ir_cmd)
                8'h01: begin rec = 1; want_n = 2; man_n = 1; age_n = 0; end
                8'h02: begin rec = 1; want_n = 2; man_n = 4; age_n = 0; end
                8'h03: begin rec = 1; want_n = 2; man_n = 2; age_n = 0; end
                8'h04: begin rec = 1; want_n = 2; man_n = 3; age_n = 0; end
                8'h05: begin rec = 1; want_n = 2; man_n = 0; age_n = 0; end
                8'h0A: begin rec = 1; want_n = 1; end
                8'h0B: begin rec = 1; want_n = 0; end
                default: ;
            endcase
        end
        if (!rec && m_mode == 2) begin
            if (m_age >= T - 1) want_n = 1;
            else age_n = m_age + 1;
        end
        mode_n = (m_blk != 0) ? 3 : want_n;
        case (mode_n)
            2: drive_n = man_n;
            1: begin
                if (!orange_detected || m_filt == 0) drive_n = 5;
                else if (m_filt == 1) drive_n = 2;
                else if (m_filt == 2) drive_n = 1;
                else drive_n = 3;
            end
            default: drive_n = 0;
        endcase

        pend_n = m_pend; cmd_n = m_cmd; last_n = m_last; idle_n = m_idle;
        if (m_pend == 0) begin
            if (m_drive != m_last || m_idle == H - 1) begin
                pend_n = 1; cmd_n = m_drive;
            end else begin
                idle_n = m_idle + 1;
            end
        end else if (cmd_ready) begin
            pend_n = 0; last_n = m_cmd; idle_n = 0;
        end

        m_dir = dir; m_run = run_n; m_filt = filt_n; m_blk = blk_n;
        m_want = want_n; m_man = man_n; m_age = age_n; m_mode = mode_n; m_drive = drive_n;
        m_pend = pend_n; m_cmd = cmd_n; m_last = last_n; m_idle = idle_n;
    endtask

    always @(posedge clk_50 or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_50);
        @(negedge clk_50);
    endtask

    task automatic ir_pulse(input logic [7:0] code);
        ir_cmd = code;
        ir_valid = 1'b1;
        tick();
        ir_valid = 1'b0;
    endtask

    task automatic dist_pulse(input int d);
        distance = DW'(d);
        dist_valid = 1'b1;
        tick();
        dist_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int early;
        total++;
        if ({mode, drive_state, cmd_valid, cmd_state, blocked} !== 12'd0) begin
            bad++;
            $display("FAIL reset_state: got mode=%0d drive=%0d valid=%0d cmd=%0d blk=%0d, expected all 0",
                     mode, drive_state, cmd_valid, cmd_state, blocked);
        end
        early = 0;
        for (int i = 1; i <= 49; i++) begin
            tick();
            if (cmd_valid !== 1'b0 && early == 0) early = i;
        end
        total++;
        if (early !== 0) begin
            bad++;
            $display("FAIL reset_quiet: cmd_valid rose at cycle %0d, expected low for 49 cycles", early);
        end
        tick();
        total++;
        if (cmd_valid !== 1'b1 || cmd_state !== 4'd0) begin
            bad++;
            $display("FAIL heartbeat_req: got valid=%0d cmd=%0d, expected valid=1 cmd=0", cmd_valid, cmd_state);
        end
        tick();
        total++;
        if (cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL heartbeat_ack: got valid=%0d, expected 0", cmd_valid);
        end
    endtask

    task automatic test_camera_filter();
        int wrong, first;
        orange_detected = 1'b1;
        cam_dir = 3'd1;
        ir_pulse(8'h0A);
        total++;
        if (mode !== 2'd1 || drive_state !== 4'd5) begin
            bad++;
            $display("FAIL auto_entry: got mode=%0d drive=%0d, expected mode=1 drive=5", mode, drive_state);
        end
        wrong = 0;
        for (int i = 1; i <= 16; i++) begin
            cam_dir = (((i / 2) % 2) == 0) ? 3'd1 : 3'd3;
            tick();
            if (drive_state !== 4'd5) wrong++;
        end
        total++;
        if (wrong !== 0) begin
            bad++;
            $display("FAIL cam_toggle: drive left SEARCH on %0d cycles, expected 0", wrong);
        end
        cam_dir = 3'd2;
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (drive_state === 4'd1 && first == 0) first = k;
        end
        total++;
        if (first < 1 || first > 5) begin
            bad++;
            $display("FAIL cam_accept: drive became FWD after %0d cycles, expected 1..5", first);
        end
    endtask

    task automatic test_manual_timeout();
        int first;
        ir_pulse(8'h03);
        total++;
        if (mode !== 2'd2 || drive_state !== 4'd2) begin
            bad++;
            $display("FAIL manual_entry: got mode=%0d drive=%0d, expected mode=2 drive=2", mode, drive_state);
        end
        first = 0;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (mode === 2'd1 && first == 0) first = k;
        end
        total++;
        if (first !== 20) begin
            bad++;
            $display("FAIL manual_timeout: mode returned to AUTO after %0d cycles, expected 20", first);
        end
        total++;
        if (drive_state !== 4'd1) begin
            bad++;
            $display("FAIL timeout_drive: got drive=%0d, expected 1", drive_state);
        end
    endtask

    task automatic test_obstacle();
        ir_pulse(8'h01);
        dist_pulse(15);
        total++;
        if (blocked !== 1'b1) begin
            bad++;
            $display("FAIL block_set: got blocked=%0d, expected 1", blocked);
        end
        tick();
        total++;
        if (mode !== 2'd3 || drive_state !== 4'd0) begin
            bad++;
            $display("FAIL block_stop: got mode=%0d drive=%0d, expected mode=3 drive=0", mode, drive_state);
        end
        dist_pulse(25);
        tick();
        total++;
        if (blocked !== 1'b1 || mode !== 2'd3) begin
            bad++;
            $display("FAIL block_hold25: got blocked=%0d mode=%0d, expected blocked=1 mode=3", blocked, mode);
        end
        dist_pulse(30);
        total++;
        if (blocked !== 1'b0) begin
            bad++;
            $display("FAIL block_clear30: got blocked=%0d, expected 0", blocked);
        end
        tick();
        total++;
        if (mode !== 2'd2 || drive_state !== 4'd1) begin
            bad++;
            $display("FAIL block_restore: got mode=%0d drive=%0d, expected mode=2 drive=1", mode, drive_state);
        end
        dist_pulse(20);
        total++;
        if (blocked !== 1'b0) begin
            bad++;
            $display("FAIL dist_eq_stop: got blocked=%0d, expected 0", blocked);
        end
        dist_pulse(0);
        total++;
        if (blocked !== 1'b1) begin
            bad++;
            $display("FAIL dist_zero: got blocked=%0d, expected 1", blocked);
        end
        dist_pulse(29);
        total++;
        if (blocked !== 1'b1) begin
            bad++;
            $display("FAIL dist_29_hold: got blocked=%0d, expected 1", blocked);
        end
        dist_pulse(30);
        tick();
    endtask

    task automatic test_back_pressure();
        int wrong;
        ir_pulse(8'h05);
        repeat (4) tick();
        cmd_ready = 1'b0;
        ir_pulse(8'h01);
        tick();
        wrong = 0;
        if (cmd_valid !== 1'b1 || cmd_state !== 4'd1) wrong++;
        ir_pulse(8'h03);
        if (cmd_valid !== 1'b1 || cmd_state !== 4'd1) wrong++;
        tick();
        if (cmd_valid !== 1'b1 || cmd_state !== 4'd1) wrong++;
        ir_pulse(8'h04);
        if (cmd_valid !== 1'b1 || cmd_state !== 4'd1) wrong++;
        tick();
        if (cmd_valid !== 1'b1 || cmd_state !== 4'd1) wrong++;
        total++;
        if (wrong !== 0) begin
            bad++;
            $display("FAIL bp_hold: cmd_state/valid disturbed on %0d cycles, expected valid=1 cmd=1 throughout", wrong);
        end
        cmd_ready = 1'b1;
        tick();
        total++;
        if (cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_ack: got valid=%0d, expected 0", cmd_valid);
        end
        tick();
        total++;
        if (cmd_valid !== 1'b1 || cmd_state !== 4'd3) begin
            bad++;
            $display("FAIL bp_next: got valid=%0d cmd=%0d, expected valid=1 cmd=3", cmd_valid, cmd_state);
        end
    endtask

    task automatic test_async_reset();
        int early;
        cmd_ready = 1'b0;
        ir_pulse(8'h01);
        tick();
        total++;
        if (cmd_valid !== 1'b1) begin
            bad++;
            $display("FAIL ar_pending: got valid=%0d, expected 1", cmd_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (cmd_valid !== 1'b0 || mode !== 2'd0 || drive_state !== 4'd0) begin
            bad++;
            $display("FAIL ar_drop: got valid=%0d mode=%0d drive=%0d, expected 0 0 0", cmd_valid, mode, drive_state);
        end
        @(negedge clk_50);
        reset = 1'b0;
        cmd_ready = 1'b1;
        cam_dir = 3'd0;
        early = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (cmd_valid !== 1'b0 && early == 0) early = i;
        end
        total++;
        if (early !== 0) begin
            bad++;
            $display("FAIL ar_quiet: cmd_valid rose at cycle %0d after reset, expected low", early);
        end
    endtask

    task automatic test_random(input int n);
        int codes [9] = '{1, 2, 3, 4, 5, 8'h0A, 8'h0B, 7, 8'hFF};
        logic [11:0] got, exp;
        for (int i = 0; i < n; i++) begin
            ir_valid = ($urandom_range(0, 9) == 0);
            ir_cmd   = 8'(codes[$urandom_range(0, 8)]);
            if ($urandom_range(0, 5) == 0) cam_dir = 3'($urandom_range(0, 7));
            orange_detected = ($urandom_range(0, 7) != 0);
            dist_valid = ($urandom_range(0, 7) == 0);
            distance = DW'($urandom_range(0, 60));
            if ($urandom_range(0, 9) == 0) distance = DW'($urandom);
            cmd_ready = ($urandom_range(0, 1) == 1);
            tick();
            got = {drive_state, mode, cmd_valid, cmd_state, blocked};
            exp = {4'(m_drive), 2'(m_mode), 1'(m_pend), 4'(m_cmd), 1'(m_blk)};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL random_cycle %0d: got drive=%0d mode=%0d valid=%0d cmd=%0d blk=%0d, expected drive=%0d mode=%0d valid=%0d cmd=%0d blk=%0d",
                         i, got[11:8], got[7:6], got[5], got[4:1], got[0],
                         exp[11:8], exp[7:6], exp[5], exp[4:1], exp[0]);
            end
        end
        ir_valid = 1'b0;
        dist_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk_50);
        reset = 1'b0;
        test_reset();
        test_camera_filter();
        test_manual_timeout();
        test_obstacle();
        test_back_pressure();
        test_async_reset();
        test_random(3000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/drive_arbiter.md
# drive_arbiter

Arbitrates the robot's drive command between the obstacle sensor, the IR remote and the camera classifier, and sequences delivery of the chosen command to the UART JSON transmitter. It sits in the top level between the sensor/IR/classification outputs and `json_to_uart_top`, replacing ad-hoc priority logic with one registered decision and a valid/ready transmit handshake. It also adds manual-mode timeout, camera-direction filtering, obstacle hysteresis and periodic heartbeat resends.

## Interface
- `STABLE_CYCLES`, default 250000: cycles a camera direction must persist before it is accepted (5 ms at 50 MHz).
- `MANUAL_TIMEOUT`, default 100000000: cycles without an IR command before manual mode expires (2 s).
- `HEARTBEAT`, default 25000000: cycles between repeat transmissions of an unchanged command (0.5 s).
- `DIST_W`, default 18: distance width.
- `STOP_DIST`, default 20: obstacle threshold, in distance units.
- `CLEAR_DIST`, default 30: release threshold. Must be greater than or equal to `STOP_DIST`.
- `clk_50  in  1`: system clock, 50 MHz.
- `reset  in  1`: asynchronous, active-high reset.
- `ir_cmd  in  8`: IR button code. Sampled only when `ir_valid` is high.
- `ir_valid  in  1`: one-cycle strobe marking a new IR code.
- `cam_dir  in  3`: camera direction. 0 = none, 1 = left, 2 = centre, 3 = right. Values 4–7 are treated as none.
- `orange_detected  in  1`: level input; target currently visible.
- `distance  in  DIST_W`: ultrasonic range, unsigned.
- `dist_valid  in  1`: one-cycle strobe marking a fresh `distance` value.
- `drive_state  out  4`: current arbitrated command. 0 STOP, 1 FWD, 2 LEFT, 3 RIGHT, 4 REV, 5 SEARCH.
- `mode  out  2`: current mode. 0 IDLE, 1 AUTO, 2 MANUAL, 3 BLOCKED.
- `cmd_valid  out  1`: a transmit request is pending.
- `cmd_state  out  4`: command being transmitted. Held stable while `cmd_valid` is high.
- `cmd_ready  in  1`: transmitter accepts the command.
- `blocked  out  1`: obstacle latch.

## Operation
- Reset values: `drive_state`=0, `mode`=IDLE, `cmd_valid`=0, `cmd_state`=0, `blocked`=0, all counters 0.
- **Obstacle latch:**
  - Updated only on `dist_valid`.
  - Set when `distance < STOP_DIST`.
  - Cleared when `distance >= CLEAR_DIST`.
  - Otherwise holds its value.
  - A distance of 0 is treated as an obstacle.
- **Camera filter:**
  - A candidate register holds the last `cam_dir` seen; a counter tracks how long it has persisted.
  - The counter resets to 0 whenever `cam_dir` differs from the candidate.
  - When the counter reaches `STABLE_CYCLES-1`, the candidate is copied to `cam_filt`.
  - The counter saturates and does not wrap.
- **IR decode**, on `ir_valid`:
  - 0x01 → FWD; 0x02 → REV; 0x03 → LEFT; 0x04 → RIGHT; 0x05 → STOP. Each of these enters MANUAL and reloads the timeout.
  - 0x0A → AUTO.
  - 0x0B → IDLE.
  - Other codes are ignored and do not reload the timeout.
- **Mode priority**, evaluated every cycle, highest first:
  - `blocked` → BLOCKED.
  - Otherwise an `ir_valid` decode in the same cycle.
  - Otherwise MANUAL times out to AUTO when the timeout counter reaches `MANUAL_TIMEOUT-1` with no valid IR.
  - Otherwise the current mode holds.
- **Leaving BLOCKED:** when `blocked` clears, the mode returns to the pre-block mode (saved on entry). A valid IR command received while blocked updates the saved mode and saved manual command, but `drive_state` stays STOP.
- **`drive_state` per mode:**
  - IDLE and BLOCKED → STOP.
  - MANUAL → last decoded manual command.
  - AUTO: if `orange_detected` is 0 or `cam_filt` is none → SEARCH. Otherwise left → LEFT, centre → FWD, right → RIGHT.
- **Transmit sequencing**, a two-state FSM (IDLE_TX, WAIT_ACK):
  - IDLE_TX → WAIT_ACK when either:
    - `drive_state` differs from the last transmitted value, or
    - the heartbeat counter reaches `HEARTBEAT-1`.
  - On that transition, `cmd_state` is loaded with `drive_state` and `cmd_valid` is raised.
  - WAIT_ACK → IDLE_TX when `cmd_ready` && `cmd_valid`. At that point the last-sent value is updated and the heartbeat counter clears.
  - The heartbeat counter runs only in IDLE_TX.
  - If `drive_state` changes during WAIT_ACK, `cmd_state` is not altered. The mismatch is detected after returning to IDLE_TX, giving a new request one cycle later.
- **Reset mid-transaction:** `cmd_valid` drops immediately (asynchronously). After reset the last-sent value is 0, so no transmit is issued until `drive_state` becomes nonzero or the heartbeat expires.

## Timing
- `ir_valid` → `mode`/`drive_state` updated at the next clock edge: 1-cycle latency.
- `dist_valid` → `blocked` after 1 cycle; `drive_state`=STOP after 2 cycles.
- Camera direction change → `cam_filt` after `STABLE_CYCLES` cycles; `drive_state` one cycle later.
- `drive_state` change → `cmd_valid` high on the next cycle. `cmd_valid` may not depend combinationally on `cmd_ready`.
- Handshake completes on any cycle with `cmd_valid` and `cmd_ready` both high. The minimum gap between requests is 1 cycle.
- All outputs are registered.

## Test plan
Run all scenarios with `STABLE_CYCLES`=4, `MANUAL_TIMEOUT`=20, `HEARTBEAT`=50.
- **Reset:** reset released, `cmd_ready`=1 → `mode`=0, `drive_state`=0, `cmd_valid`=0 for 49 cycles, then a heartbeat request with `cmd_state`=0.
- **Camera filter:** `ir_cmd`=0x0A pulse, `orange_detected`=1, `cam_dir` toggling 1/3 every 2 cycles → `drive_state` stays 5. Holding `cam_dir`=2 → `drive_state`=1 within 5 cycles.
- **Manual timeout:** `ir_cmd`=0x03 pulse → `mode`=2, `drive_state`=2 next cycle. With no further IR, `mode` returns to 1 after 20 cycles.
- **Obstacle hysteresis:**
  - `distance`=15 with `dist_valid` during MANUAL FWD → `blocked`=1, `drive_state`=0.
  - `distance`=25 → still blocked.
  - `distance`=30 → `mode`=2, `drive_state`=1.
- **Back-pressure:**
  - Hold `cmd_ready`=0 and change FWD → LEFT → RIGHT → `cmd_state` stays at the first value (1) while `cmd_valid` is high.
  - Release `cmd_ready` → the next request carries 3.
- **Async reset in WAIT_ACK:** assert `reset` mid-cycle → `cmd_valid` falls without waiting for a clock edge.
